// File: rtl/regs_pkg.sv
// Shared types and default sizes for the integer register file and its write-port controller.
package regs_pkg;

    localparam int REGS_DATA_WIDTH  = 16;
    localparam int REGS_INDEX_WIDTH = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/regs_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from the valids and the last winner.
module regs_rr_arb2
    import regs_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    req_e last_q, last_d;

    always_comb begin
        o_grant[0] = i_valid[0] && (!i_valid[1] || (last_q == REQ_B));
        o_grant[1] = i_valid[1] && (!i_valid[0] || (last_q == REQ_A));
        last_d     = last_q;
        if (i_update && o_grant[0]) begin
            last_d = REQ_A;
        end else if (i_update && o_grant[1]) begin
            last_d = REQ_B;
        end
    end

    // Resetting to B lets A win the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regs_wr_ctrl.sv
// Register-file write-port controller: round-robin between two writeback requesters.
// Optional post-reset zero sweep is built when REGS_WR_CTRL_CLEAR_EN is defined.
module regs_wr_ctrl
    import regs_pkg::*;
#(
    parameter int DATA_WIDTH  = REGS_DATA_WIDTH,
    parameter int INDEX_WIDTH = REGS_INDEX_WIDTH,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_a_valid,
    input  logic [INDEX_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0]  i_a_data,
    output logic                   o_a_ready,
    input  logic                   i_b_valid,
    input  logic [INDEX_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0]  i_b_data,
    output logic                   o_b_ready,
    output logic [INDEX_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0]  o_wdata,
    output logic                   o_we,
    output logic                   o_busy
);

    logic                   run;
    logic [1:0]             grant;
    logic                   we_q, we_d;
    logic [INDEX_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

`ifdef REGS_WR_CTRL_CLEAR_EN
    localparam logic [INDEX_WIDTH-1:0] CNT_LAST = {INDEX_WIDTH{1'b1}};
    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    assign run = (state_q == RUN);
`else
    assign run = 1'b1;
`endif

    regs_rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  ({i_b_valid, i_a_valid}),
        .i_update (run),
        .o_grant  (grant)
    );

    assign o_a_ready = run && grant[0];
    assign o_b_ready = run && grant[1];
    assign o_busy    = !run;
    assign o_we      = we_q;
    assign o_waddr   = waddr_q;
    assign o_wdata   = wdata_q;

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (o_a_ready) begin
            we_d    = !(ZERO_REG && (i_a_addr == '0));
            waddr_d = i_a_addr;
            wdata_d = i_a_data;
        end else if (o_b_ready) begin
            we_d    = !(ZERO_REG && (i_b_addr == '0));
            waddr_d = i_b_addr;
            wdata_d = i_b_data;
        end
`ifdef REGS_WR_CTRL_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        // Index 0 is swept too, even when it is the hardwired zero register.
        if (state_q == CLEAR) begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = RUN;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef REGS_WR_CTRL_CLEAR_EN
            state_q <= CLEAR;
            cnt_q   <= '0;
`endif
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef REGS_WR_CTRL_CLEAR_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
